deserializer_sipo: RTL and testbench
====================================

# deserializer_sipo

Serial-input, parallel-output (SIPO) deserializer: the receive-side stage directly downstream of the transceiver's PISO serializer. It samples one bit per bit strobe, LSB first, assembles `DATA_WIDTH`-bit words aligned by a frame-start marker, and presents each completed word on a valid/ready parallel interface. It detects and flags resynchronisation and overrun conditions.

## Interface
- `DATA_WIDTH`, 8: word width in bits; legal range is 2 or more.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `srl_in`  in  1  serial data bit; sampled only when `bit_en`=1.
- `bit_en`  in  1  bit strobe; one bit is consumed per cycle in which it is high.
- `frm_start`  in  1  marks the current bit as bit 0 of a word; ignored unless `bit_en`=1.
- `data_out`  out  DATA_WIDTH  assembled word; the first received bit is `data_out[0]`.
- `data_valid`  out  1  `data_out` holds an unconsumed word.
- `data_ready`  in  1  consumer accepts `data_out` when `data_valid & data_ready`.
- `rx_active`  out  1  high while a word is partially received (FSM in SHIFT).
- `frm_err`  out  1  one-cycle pulse: a word was restarted by `frm_start` before completion.
- `overrun`  out  1  sticky; a completed word was dropped; cleared only by `rst`.

## Operation
- FSM has two states.
  - IDLE: bits are ignored unless `bit_en & frm_start`. On that event: shift in the bit, set count=1, go to SHIFT.
  - SHIFT: each `bit_en` shifts right, `sr <= {srl_in, sr[W-1:1]}`, and increments count.
- Count register is `$clog2(DATA_WIDTH+1)` bits wide and never exceeds `DATA_WIDTH`.
- Completion is the edge that samples bit W-1 (count W-1 → W). On that edge:
  - the completed word `{srl_in, sr[W-1:1]}` goes to the output stage;
  - the FSM returns to IDLE and count is cleared.
- `frm_start & bit_en` in SHIFT always takes priority. The partial word is discarded, the new bit is taken as bit 0, count=1, the FSM stays in SHIFT, and `frm_err` pulses on the next cycle.
  - This also applies when the restart arrives on the cycle that would have completed the word; that word is lost and is not counted as overrun.
- For W=1 frame-start-plus-completion: not applicable, because `DATA_WIDTH` ≥ 2.
- Output stage is a single holding register.
  - Completion while `data_valid`=0, or while `data_valid & data_ready`: load `data_out`, `data_valid`=1.
  - Completion while `data_valid & !data_ready`: new word dropped, `data_out` unchanged, `overrun` set.
  - `data_valid & data_ready` with no completion: `data_valid`=0. `data_out` keeps its last value.
- `bit_en`=0 cycles inside a word (gaps) are allowed and change nothing.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `rx_active`=0, `frm_err`=0, `overrun`=0; FSM in IDLE, count=0, shift register=0.
- Asserting `rst` mid-word discards the partial word and any held output word immediately, without waiting for a clock edge.
- Latency: `data_valid` rises in the cycle after the edge that samples the last bit. That is W cycles after the first bit when `bit_en` is continuous.
- `data_out` and `data_valid` are registered, with no combinational path from `srl_in` or `data_ready`.
- `data_valid` stays high and `data_out` stays stable until the cycle after a `data_valid & data_ready` handshake.
- Back-to-back words are supported: `frm_start` may coincide with the first `bit_en` after completion, giving a sustained rate of one word per W strobes.
- `rx_active` is high from the edge after the first bit until the completion edge.

## Structure
- Shared package `srlz_pkg`:
  - `rx_state_t` enum (IDLE, SHIFT);
  - default `DATA_WIDTH` constant;
  - counter-width function/localparam.
  - The serializer uses the same package.
- Sub-module `sipo_out_stage` (valid/ready holding register plus overrun detection) is natural and reusable; the FSM, counter and shift register stay in the top module.

## Test plan
- Send 0xA5 as bits 1,0,1,0,0,1,0,1 with `bit_en` continuous, `frm_start` on bit 0, `data_ready`=1 → `data_out`=0xA5, `data_valid` high for exactly one cycle, one cycle after the 8th bit edge.
- Send 0x3C with `bit_en` every 3rd cycle → `data_out`=0x3C; `rx_active` high throughout the word; no `frm_err`.
- Send 0x11, then 0x22, with `data_ready`=0 → `data_out` stays 0x11 and `overrun`=1. Raise `data_ready` → `data_valid` falls; `overrun` remains 1 until `rst`.
- Send 4 bits of a word, then `frm_start` with 0xF0 → `frm_err` pulses once; `data_out`=0xF0.
- Assert `rst` after 5 bits of 0xFF → all outputs are 0 immediately. Then send 0x81 → `data_out`=0x81 with no stale bits.
- Send 0x01, 0x80, 0x55 back to back with `data_ready`=1 → three valid words in order, spaced 8 cycles apart, with no overrun.

Source files
------------

// File: rtl/srlz_pkg.sv
`default_nettype none
// ============================================================================
// Module   : srlz_pkg
// Brief    : Shared types and constants for the serializer / deserializer pair.
// Revision : 1.0 - initial release
// ============================================================================
package srlz_pkg;

  // Default word width shared by the PISO serializer and SIPO deserializer.
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Receive FSM states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  // Bit counter width: must be able to hold the value DATA_WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : sipo_out_stage
// Brief    : Single-entry valid/ready holding register with sticky overrun.
//            A word offered while the register is full and not being drained
//            is dropped and flagged.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_out_stage
  import srlz_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  overrun
);

  // The register is free when empty or when its word is leaving this cycle.
  logic slot_free;
  assign slot_free = !data_valid || data_ready;

  // Holding register: load on completion if free, otherwise drop and flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (load) begin
      if (slot_free) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else begin
        overrun    <= 1'b1;
      end
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/deserializer_sipo.sv
`default_nettype none
// ============================================================================
// Module   : deserializer_sipo
// Brief    : Serial-in / parallel-out deserializer. Bits arrive LSB first on
//            each bit_en strobe, words are aligned by frm_start, and completed
//            words are presented through a valid/ready holding register.
// Revision : 1.0 - initial release
// ============================================================================
module deserializer_sipo
  import srlz_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  srl_in,
  input  logic                  bit_en,
  input  logic                  frm_start,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  rx_active,
  output logic                  frm_err,
  output logic                  overrun
);

  localparam int              CW       = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_WIDTH - 1);

  rx_state_t             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] word;
  logic                  complete;
  logic                  restart;

  // The incoming bit enters at the MSB; after the last bit, bit 0 sits at LSB.
  assign word = {srl_in, sr_q[DATA_WIDTH-1:1]};

  // State, counter and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  // Next-state logic; a frame restart in SHIFT outranks word completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    complete = 1'b0;
    restart  = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (frm_start) begin
            sr_d    = word;
            cnt_d   = CNT_ONE;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          sr_d = word;
          if (frm_start) begin
            // Partial word discarded; this bit becomes bit 0 of a new word.
            cnt_d   = CNT_ONE;
            restart = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // One-cycle frame error pulse following a restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_err <= 1'b0;
    end else begin
      frm_err <= restart;
    end
  end

  assign rx_active = (state_q == SHIFT);

  sipo_out_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .load      (complete),
    .word      (word),
    .data_ready(data_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .overrun   (overrun)
  );

endmodule
`default_nettype wire

// File: tb/tb_deserializer_sipo.sv
`default_nettype none
// ============================================================================
// Module   : tb_deserializer_sipo
// Brief    : Directed, scoreboard-based bench for deserializer_sipo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deserializer_sipo;

  logic       clk = 1'b0;
  logic       rst;
  logic       srl_in;
  logic       bit_en;
  logic       frm_start;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       rx_active;
  logic       frm_err;
  logic       overrun;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int frm_err_cnt = 0;
  logic [7:0] sb_q[$];
  int acc_cyc[$];

  deserializer_sipo #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .srl_in    (srl_in),
    .bit_en    (bit_en),
    .frm_start (frm_start),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .rx_active (rx_active),
    .frm_err   (frm_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Cycle counter for spacing checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted word must match the oldest expected one.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (frm_err === 1'b1) frm_err_cnt++;
      if (data_valid === 1'b1 && data_ready === 1'b1) begin
        acc_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          check("unexpected_word", {24'h0, data_out}, 32'hFFFF_FFFF);
        end else begin
          check("sb_word", {24'h0, data_out}, {24'h0, sb_q.pop_front()});
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // Drive nbits of w LSB first, frm_start on bit 0, gap cycles per bit.
  task automatic send_bits(input logic [7:0] w, input int nbits, input int gap,
                           input bit check_mid);
    for (int i = 0; i < nbits; i++) begin
      srl_in    = w[i];
      bit_en    = 1'b1;
      frm_start = (i == 0);
      @(posedge clk); #1;
      bit_en    = 1'b0;
      frm_start = 1'b0;
      if (check_mid && i < 7) begin
        check("rx_active_mid", {31'h0, rx_active}, 32'h1);
        check("valid_mid", {31'h0, data_valid}, 32'h0);
      end
      if (i < nbits - 1) begin
        for (int g = 1; g < gap; g++) begin
          @(posedge clk); #1;
          if (check_mid) check("rx_active_gap", {31'h0, rx_active}, 32'h1);
        end
      end
    end
  endtask

  initial begin
    int fe0;
    rst = 1'b1; srl_in = 1'b0; bit_en = 1'b0; frm_start = 1'b0; data_ready = 1'b1;
    idle(2);
    check("rst_data_out", {24'h0, data_out}, 32'h0);
    check("rst_valid", {31'h0, data_valid}, 32'h0);
    check("rst_rx_active", {31'h0, rx_active}, 32'h0);
    check("rst_frm_err", {31'h0, frm_err}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    rst = 1'b0;
    idle(2);

    // 0xA5 continuous; valid exactly one cycle after the 8th bit edge.
    sb_q.push_back(8'hA5);
    send_bits(8'hA5, 8, 1, 1'b1);
    check("a5_valid", {31'h0, data_valid}, 32'h1);
    check("a5_data", {24'h0, data_out}, 32'hA5);
    check("a5_rx_done", {31'h0, rx_active}, 32'h0);
    idle(1);
    check("a5_valid_drop", {31'h0, data_valid}, 32'h0);
    idle(2);

    // 0x3C with a strobe every third cycle.
    fe0 = frm_err_cnt;
    sb_q.push_back(8'h3C);
    send_bits(8'h3C, 8, 3, 1'b1);
    check("3c_data", {24'h0, data_out}, 32'h3C);
    idle(2);
    check("3c_no_frm_err", frm_err_cnt - fe0, 32'h0);

    // Overrun: 0x11 held, 0x22 dropped.
    data_ready = 1'b0;
    sb_q.push_back(8'h11);
    send_bits(8'h11, 8, 1, 1'b0);
    send_bits(8'h22, 8, 1, 1'b0);
    idle(1);
    check("ovr_data_held", {24'h0, data_out}, 32'h11);
    check("ovr_valid", {31'h0, data_valid}, 32'h1);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    data_ready = 1'b1;
    idle(1);
    check("ovr_valid_drop", {31'h0, data_valid}, 32'h0);
    idle(3);
    check("ovr_sticky", {31'h0, overrun}, 32'h1);

    // Restart after 4 bits, then 0xF0.
    fe0 = frm_err_cnt;
    send_bits(8'hFF, 4, 1, 1'b0);
    sb_q.push_back(8'hF0);
    send_bits(8'hF0, 8, 1, 1'b0);
    check("restart_data", {24'h0, data_out}, 32'hF0);
    idle(3);
    check("restart_frm_err_once", frm_err_cnt - fe0, 32'h1);
    check("restart_frm_err_low", {31'h0, frm_err}, 32'h0);

    // Asynchronous reset with a held word and a partial word in flight.
    data_ready = 1'b0;
    send_bits(8'h5A, 8, 1, 1'b0);
    send_bits(8'hFF, 5, 1, 1'b0);
    check("pre_rst_rx_active", {31'h0, rx_active}, 32'h1);
    check("pre_rst_valid", {31'h0, data_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_data_out", {24'h0, data_out}, 32'h0);
    check("arst_valid", {31'h0, data_valid}, 32'h0);
    check("arst_rx_active", {31'h0, rx_active}, 32'h0);
    check("arst_overrun", {31'h0, overrun}, 32'h0);
    check("arst_frm_err", {31'h0, frm_err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    data_ready = 1'b1;
    idle(1);
    sb_q.push_back(8'h81);
    send_bits(8'h81, 8, 1, 1'b0);
    check("post_rst_data", {24'h0, data_out}, 32'h81);
    idle(3);

    // Back-to-back words at one word per eight strobes.
    acc_cyc.delete();
    sb_q.push_back(8'h01); sb_q.push_back(8'h80); sb_q.push_back(8'h55);
    send_bits(8'h01, 8, 1, 1'b0);
    send_bits(8'h80, 8, 1, 1'b0);
    send_bits(8'h55, 8, 1, 1'b0);
    idle(3);
    check("b2b_count", acc_cyc.size(), 32'd3);
    if (acc_cyc.size() == 3) begin
      check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 32'd8);
      check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 32'd8);
    end
    check("b2b_no_overrun", {31'h0, overrun}, 32'h0);
    check("sb_empty", sb_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
